// File: rtl/periph_bus_responder_if.sv
// -----------------------------------------------------------------------------
// periph_bus_responder_if
//   CPU-to-peripheral data-path bundle used by the memory-mapped responder.
//
//   Signals:
//     rd     read strobe (CPU MemRead)
//     wr     write strobe (CPU PerWr, already gated by address bit 30)
//     addr   byte address (CPU ALUOut)
//     wdata  write data (CPU DataBusB)
//     rdata  read data returned to the CPU (PerData)
//
//   Modports:
//     master  CPU side: drives the strobes, address and write data
//     slave   responder side: drives the read data
// -----------------------------------------------------------------------------
interface periph_bus_responder_if;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (output rd, output wr, output addr, output wdata, input rdata);
  modport slave  (input rd, input wr, input addr, input wdata, output rdata);
endinterface

// File: rtl/periph_bus_responder.sv
// -----------------------------------------------------------------------------
// periph_bus_responder
//   Memory-mapped peripheral responder in a 64-byte window at BASE_ADDR.
//   Owns a reloadable 32-bit up-counting timer with interrupt, an LED
//   register, a synchronized switch input and a 7-segment drive register.
//
//   Register map (offset from BASE_ADDR, index = addr[5:2]):
//     0x00 TH      rw  timer reload value
//     0x04 TL      rw  timer count
//     0x08 TCON    rw  [0] timer enable, [1] irq enable, [2] irq status
//     0x0C LED     rw  [7:0]
//     0x10 SWITCH  ro  synchronized switches, zero-extended
//     0x14 DIGI    rw  [11:0] (anode select [11:8], segments [7:0])
//     0x18 SYSTICK ro  free-running cycle counter, only when the
//                      PERIPH_SYSTICK_EN macro is defined; otherwise unmapped
//
//   Parameters:
//     BASE_ADDR       window base, 64-byte aligned
//     SW_SYNC_STAGES  switch synchronizer depth, 2 or more
//
//   Ports:
//     clk     single clock, rising edge
//     reset   synchronous active-high reset
//     bus     slave side of the CPU peripheral bus (rd/wr/addr/wdata/rdata)
//     irqout  level interrupt request, TCON[1] & TCON[2]
//     led     LED drive
//     switch  asynchronous board switches
//     digi    7-segment drive
// -----------------------------------------------------------------------------
module periph_bus_responder #(
  parameter logic [31:0] BASE_ADDR      = 32'h4000_0000,
  parameter int          SW_SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  periph_bus_responder_if.slave       bus,
  output logic                        irqout,
  output logic [7:0]                  led,
  input  logic [7:0]                  switch,
  output logic [11:0]                 digi
);

  typedef enum logic [3:0] {
    REG_TH      = 4'h0,
    REG_TL      = 4'h1,
    REG_TCON    = 4'h2,
    REG_LED     = 4'h3,
    REG_SWITCH  = 4'h4,
    REG_DIGI    = 4'h5,
    REG_SYSTICK = 4'h6
  } reg_idx_e;

  localparam int TCON_TEN  = 0;
  localparam int TCON_IEN  = 1;
  localparam int TCON_IST  = 2;

  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [7:0]  led_q;
  logic [11:0] digi_q;
  logic [SW_SYNC_STAGES-1:0][7:0] sw_sync;

  logic        sel;
  logic        wr_sel;
  reg_idx_e    reg_idx;

  // Byte lane bits carry no information for word registers.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = &{1'b0, bus.addr[1:0]};

  assign sel     = (bus.addr[31:6] == BASE_ADDR[31:6]);
  assign wr_sel  = bus.wr & sel;
  assign reg_idx = reg_idx_e'(bus.addr[5:2]);

  // ---------------------------------------------------------------------------
  // Timer and software-writable registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      th     <= '0;
      tl     <= '0;
      tcon   <= '0;
      led_q  <= '0;
      digi_q <= '0;
    end else begin
      if (tcon[TCON_TEN]) begin
        if (tl == 32'hFFFF_FFFF) begin
          tl <= th;
          if (tcon[TCON_IEN]) begin
            tcon[TCON_IST] <= 1'b1;
          end
        end else begin
          tl <= tl + 32'd1;
        end
      end

      // NOTE: the software write comes after the timer update on purpose:
      // the last non-blocking assignment in a block wins, so a write to TL
      // or TCON overrides the same-cycle tick/reload/status set, while a TH
      // write leaves the reload above using the old TH value.
      if (wr_sel) begin
        unique case (reg_idx)
          REG_TH:   th     <= bus.wdata;
          REG_TL:   tl     <= bus.wdata;
          REG_TCON: tcon   <= bus.wdata[2:0];
          REG_LED:  led_q  <= bus.wdata[7:0];
          REG_DIGI: digi_q <= bus.wdata[11:0];
          default:  ;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Switch synchronizer: a plain shift chain, readback from the last stage
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_sync <= '0;
    end else begin
      sw_sync <= {sw_sync[SW_SYNC_STAGES-2:0], switch};
    end
  end

`ifdef PERIPH_SYSTICK_EN
  // ---------------------------------------------------------------------------
  // Free-running cycle counter, wraps at 2^32, not writable
  // ---------------------------------------------------------------------------
  logic [31:0] systick;

  always_ff @(posedge clk) begin
    if (reset) begin
      systick <= '0;
    end else begin
      systick <= systick + 32'd1;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Combinational read mux: zero unless a selected read is in progress
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: the default assignment first keeps every path driven, so no
    // latch is inferred for unmapped offsets or idle cycles.
    bus.rdata = 32'h0;
    if (bus.rd && sel) begin
      unique case (reg_idx)
        REG_TH:      bus.rdata = th;
        REG_TL:      bus.rdata = tl;
        REG_TCON:    bus.rdata = {29'h0, tcon};
        REG_LED:     bus.rdata = {24'h0, led_q};
        REG_SWITCH:  bus.rdata = {24'h0, sw_sync[SW_SYNC_STAGES-1]};
        REG_DIGI:    bus.rdata = {20'h0, digi_q};
`ifdef PERIPH_SYSTICK_EN
        REG_SYSTICK: bus.rdata = systick;
`endif
        default:     bus.rdata = 32'h0;
      endcase
    end
  end

  assign irqout = tcon[TCON_IEN] & tcon[TCON_IST];
  assign led    = led_q;
  assign digi   = digi_q;

endmodule

// File: tb/tb_periph_bus_responder.sv
// -----------------------------------------------------------------------------
// tb_periph_bus_responder
//   Directed and randomized bench for periph_bus_responder. A behavioural
//   model of the register map (plain variables plus a queue standing in for
//   the switch synchronizer delay) predicts every read and output pin.
// -----------------------------------------------------------------------------
module tb_periph_bus_responder;

  localparam logic [31:0] BASE      = 32'h4000_0000;
  localparam logic [25:0] BASE_HI   = 26'h100_0000;
  localparam int          SYNC      = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        irqout;
  logic [7:0]  led;
  logic [7:0]  switch;
  logic [11:0] digi;

  periph_bus_responder_if bus_if ();

  periph_bus_responder #(
    .BASE_ADDR      (BASE),
    .SW_SYNC_STAGES (SYNC)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus_if),
    .irqout (irqout),
    .led    (led),
    .switch (switch),
    .digi   (digi)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [31:0] m_th, m_tl, m_tick;
  logic [2:0]  m_tcon;
  logic [7:0]  m_led;
  logic [11:0] m_digi;
  logic [7:0]  sw_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_th = 0; m_tl = 0; m_tcon = 0; m_led = 0; m_digi = 0; m_tick = 0;
    sw_q = {};
    repeat (SYNC) sw_q.push_back(8'h00);
  endtask

  // One rising edge of the modelled block, using the inputs as driven now.
  task automatic model_step();
    logic [31:0] n_tl;
    logic [2:0]  n_tcon;
    if (reset) begin
      model_reset();
    end else begin
      n_tl   = m_tl;
      n_tcon = m_tcon;
      m_tick = m_tick + 1;
      sw_q.push_back(switch);
      void'(sw_q.pop_front());
      if (m_tcon[0]) begin
        if (m_tl == 32'hFFFF_FFFF) begin
          n_tl = m_th;
          if (m_tcon[1]) n_tcon[2] = 1'b1;
        end else begin
          n_tl = m_tl + 1;
        end
      end
      if (bus_if.wr && bus_if.addr[31:6] == BASE_HI) begin
        case (bus_if.addr[5:2])
          4'h0: m_th   = bus_if.wdata;
          4'h1: n_tl   = bus_if.wdata;
          4'h2: n_tcon = bus_if.wdata[2:0];
          4'h3: m_led  = bus_if.wdata[7:0];
          4'h5: m_digi = bus_if.wdata[11:0];
          default: ;
        endcase
      end
      m_tl   = n_tl;
      m_tcon = n_tcon;
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [3:0] idx);
    case (idx)
      4'h0: return m_th;
      4'h1: return m_tl;
      4'h2: return {29'h0, m_tcon};
      4'h3: return {24'h0, m_led};
      4'h4: return {24'h0, sw_q[0]};
      4'h5: return {20'h0, m_digi};
`ifdef PERIPH_SYSTICK_EN
      4'h6: return m_tick;
`endif
      default: return 32'h0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic wr_reg(input logic [3:0] idx, input logic [31:0] data);
    bus_if.addr  = BASE + {26'h0, idx, 2'b00};
    bus_if.wdata = data;
    bus_if.wr    = 1'b1;
    tick();
    bus_if.wr    = 1'b0;
  endtask

  task automatic rd_get(input logic [3:0] idx, output logic [31:0] val);
    bus_if.addr = BASE + {26'h0, idx, 2'($urandom_range(0, 3))};
    bus_if.rd   = 1'b1;
    #1;
    val = bus_if.rdata;
    bus_if.rd   = 1'b0;
  endtask

  task automatic rd_chk(input logic [3:0] idx, input string tag);
    logic [31:0] v;
    rd_get(idx, v);
    check(tag, v, model_rd(idx));
  endtask

  task automatic rd_const(input logic [3:0] idx, input logic [31:0] exp, input string tag);
    logic [31:0] v;
    rd_get(idx, v);
    check(tag, v, exp);
  endtask

  task automatic pins_chk(input string tag);
    check({tag, "_irq"}, {31'h0, irqout}, {31'h0, m_tcon[1] & m_tcon[2]});
    check({tag, "_led"}, {24'h0, led}, {24'h0, m_led});
    check({tag, "_digi"}, {20'h0, digi}, {20'h0, m_digi});
  endtask

  initial begin
    logic [31:0] v1, v2, frozen;
    reset        = 1'b1;
    switch       = 8'h00;
    bus_if.rd    = 1'b0;
    bus_if.wr    = 1'b0;
    bus_if.addr  = 32'h0;
    bus_if.wdata = 32'h0;
    model_reset();
    repeat (3) tick();

    // Reset state: every offset reads zero while reset is held
    for (int i = 0; i < 16; i++) rd_const(4'(i), 32'h0, $sformatf("reset_rd_%0d", i));
    check("reset_irq", {31'h0, irqout}, 32'h0);
    check("reset_led", {24'h0, led}, 32'h0);
    check("reset_digi", {20'h0, digi}, 32'h0);
    reset = 1'b0;

    // Timer overflow and reload
    wr_reg(4'h0, 32'hFFFF_FFF0);
    wr_reg(4'h1, 32'hFFFF_FFFE);
    wr_reg(4'h2, 32'h3);
    rd_const(4'h1, 32'hFFFF_FFFE, "ovf_tl_start");
    tick();
    rd_const(4'h1, 32'hFFFF_FFFF, "ovf_tl_max");
    check("ovf_irq_before", {31'h0, irqout}, 32'h0);
    tick();
    rd_const(4'h1, 32'hFFFF_FFF0, "ovf_tl_reload");
    rd_const(4'h2, 32'h7, "ovf_tcon_set");
    check("ovf_irq_set", {31'h0, irqout}, 32'h1);
    wr_reg(4'h2, 32'h3);
    check("ack_irq_clear", {31'h0, irqout}, 32'h0);
    rd_const(4'h2, 32'h3, "ack_tcon");
    rd_const(4'h1, 32'hFFFF_FFF1, "ack_tl_counting");
    repeat (14) tick();
    rd_const(4'h1, 32'hFFFF_FFFF, "ovf2_tl_max");
    check("ovf2_irq_before", {31'h0, irqout}, 32'h0);
    tick();
    rd_const(4'h1, 32'hFFFF_FFF0, "ovf2_tl_reload");
    check("ovf2_irq_set", {31'h0, irqout}, 32'h1);

    // Collision: TL write in the overflow cycle wins, status still sets
    wr_reg(4'h2, 32'h3);
    wr_reg(4'h1, 32'hFFFF_FFFE);
    tick();
    wr_reg(4'h1, 32'h5);
    rd_const(4'h1, 32'h5, "coll_tl_write_wins");
    rd_chk(4'h2, "coll_tl_tcon");
    // Collision: TCON write in the overflow cycle drops the status set
    wr_reg(4'h2, 32'h3);
    wr_reg(4'h1, 32'hFFFF_FFFF);
    wr_reg(4'h2, 32'h3);
    rd_const(4'h2, 32'h3, "coll_tcon_write_wins");
    check("coll_tcon_irq", {31'h0, irqout}, 32'h0);
    rd_const(4'h1, 32'hFFFF_FFF0, "coll_tcon_tl_reload");
    // TH write in the reload cycle: reload uses the old TH
    wr_reg(4'h1, 32'hFFFF_FFFF);
    wr_reg(4'h0, 32'h0000_0100);
    rd_const(4'h1, 32'hFFFF_FFF0, "th_coll_old_th");
    rd_const(4'h0, 32'h0000_0100, "th_coll_new_th");

    // Timer frozen when disabled
    wr_reg(4'h2, 32'h0);
    rd_get(4'h1, frozen);
    repeat (3) tick();
    rd_const(4'h1, frozen, "frozen_tl");
    rd_chk(4'h1, "frozen_tl_model");

    // Width masking
    wr_reg(4'h3, 32'hDEAD_BEA5);
    check("mask_led_pin", {24'h0, led}, 32'hA5);
    rd_const(4'h3, 32'h0000_00A5, "mask_led_rd");
    wr_reg(4'h5, 32'hFFFF_F3C6);
    check("mask_digi_pin", {20'h0, digi}, 32'h3C6);
    rd_const(4'h5, 32'h0000_03C6, "mask_digi_rd");
    wr_reg(4'h2, 32'hFFFF_FFF8);
    rd_const(4'h2, 32'h0, "mask_tcon_rd");

    // Switch synchronizer depth
    switch = 8'h5A;
    tick();
    rd_const(4'h4, 32'h0, "sw_one_edge");
    tick();
    rd_const(4'h4, 32'h0000_005A, "sw_two_edges");

    // Decode boundaries
    bus_if.addr = 32'h4000_0030; bus_if.rd = 1'b1; #1;
    check("dec_unmapped", bus_if.rdata, 32'h0);
    bus_if.addr = 32'h0000_0010; #1;
    check("dec_outside", bus_if.rdata, 32'h0);
    bus_if.addr = 32'h4000_000C; bus_if.rd = 1'b0; #1;
    check("dec_no_rd", bus_if.rdata, 32'h0);
    wr_reg(4'h4, 32'hFFFF_FFFF);
    bus_if.addr = 32'h0000_000C; bus_if.wdata = 32'h77; bus_if.wr = 1'b1;
    tick();
    bus_if.wr = 1'b0;
    for (int i = 0; i < 6; i++) rd_chk(4'(i), $sformatf("dec_nochange_%0d", i));
    check("dec_nochange_led", {24'h0, led}, 32'hA5);

    // Randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      int op;
      op = $urandom_range(0, 3);
      if ($urandom_range(0, 4) == 0) switch = 8'($urandom);
      if (op != 0) begin
        bus_if.addr  = ($urandom_range(0, 7) == 0) ? {2'b00, 30'($urandom)}
                                                   : BASE + {26'h0, 6'($urandom)};
        bus_if.wdata = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + 32'($urandom_range(0, 15))
                                                   : $urandom;
        bus_if.wr    = 1'b1;
      end
      tick();
      bus_if.wr = 1'b0;
      rd_chk(4'($urandom_range(0, 15)), $sformatf("rand_rd_%0d", n));
      pins_chk($sformatf("rand_%0d", n));
    end

    // Reset overrides a same-cycle write and a running timer
    wr_reg(4'h1, 32'h1234_0000);
    wr_reg(4'h2, 32'h3);
    reset = 1'b1;
    bus_if.addr = BASE + 32'hC; bus_if.wdata = 32'hFF; bus_if.wr = 1'b1;
    tick();
    bus_if.wr = 1'b0;
    reset = 1'b0;
    check("rst_mid_led", {24'h0, led}, 32'h0);
    rd_const(4'h1, 32'h0, "rst_mid_tl");
    rd_const(4'h2, 32'h0, "rst_mid_tcon");

    // Optional cycle counter at 0x18
    tick();
    rd_get(4'h6, v1);
    check("systick_first", v1, model_rd(4'h6));
    repeat (10) tick();
    rd_get(4'h6, v2);
`ifdef PERIPH_SYSTICK_EN
    check("systick_delta", v2 - v1, 32'd10);
`else
    check("systick_absent_a", v1, 32'h0);
    check("systick_absent_b", v2, 32'h0);
`endif
    wr_reg(4'h6, 32'hDEAD_0000);
    rd_chk(4'h6, "systick_ro");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/periph_bus_responder.md
# periph_bus_responder

Memory-mapped peripheral responder at the far end of the CPU's peripheral data path. It decodes the CPU's address, write strobe and read strobe. It returns read data on the CPU's peripheral-data input and owns a reloadable 32-bit timer, LED, switch and 7-segment display registers. It also drives the interrupt request line consumed by the CPU's control unit.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h40000000: base of the 64-byte peripheral window; must be 64-byte aligned.
- `SW_SYNC_STAGES`, default 2: synchronizer depth on `switch`; minimum 2.

Ports:
- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `rd`  in  1: read strobe; connects to the CPU MemRead.
- `wr`  in  1: write strobe; connects to the CPU PerWr, which is already gated by address bit 30.
- `addr`  in  32: byte address; connects to the CPU ALUOut.
- `wdata`  in  32: write data; connects to the CPU DataBusB.
- `rdata`  out  32: read data; connects to the CPU PerData.
- `irqout`  out  1: level interrupt request to the CPU.
- `led`  out  8: LED drive.
- `switch`  in  8: asynchronous board switches.
- `digi`  out  12: 7-segment drive, bits [11:8] anode select and [7:0] segments.

## Operation
- The block is selected when `addr[31:6] == BASE_ADDR[31:6]`. The register index is `addr[5:2]`; `addr[1:0]` is ignored.
- Register map, as offsets from `BASE_ADDR`:
  - 0x00 TH, rw, 32 bits: timer reload value.
  - 0x04 TL, rw, 32 bits: timer count.
  - 0x08 TCON, rw, bits [2:0]:
    - bit 0: timer enable.
    - bit 1: interrupt enable.
    - bit 2: interrupt status.
    - bits [31:3] read as 0.
  - 0x0C LED, rw, bits [7:0]; upper bits read 0.
  - 0x10 SWITCH, ro: synchronized switch value, zero-extended.
  - 0x14 DIGI, rw, bits [11:0]; upper bits read 0.
  - 0x18 SYSTICK: present only with the macro (see Configuration).
- Writes: when `wr` is high and the block is selected, the addressed register takes `wdata` on the rising edge, masked to the register width.
  - Writes to read-only or unmapped offsets are ignored.
- Reads: `rdata` is combinational. It carries the addressed register when `rd` is high and the block is selected; otherwise it is 32'h0.
  - Unmapped offsets read 32'h0.
- Timer, when TCON[0] = 1, each cycle:
  - If TL == 32'hFFFFFFFF, then TL <= TH, and TCON[2] <= 1 if TCON[1] = 1.
  - Otherwise TL <= TL + 1. Arithmetic is unsigned and modulo 2^32.
- The timer is frozen when TCON[0] = 0.
- `irqout` = TCON[1] & TCON[2].
  - Software clears it by writing TCON with bit 2 = 0.
  - The CPU handler must do this before re-enabling interrupts.
- Simultaneous events:
  - A software write to TL in the same cycle as a tick or reload wins; TL takes `wdata`.
  - A software write to TCON in the same cycle as an overflow wins; the overflow's status set is lost. This is intended, because the handler clears the status and re-arms in one write.
  - A write to TH in the reload cycle: the reload uses the old TH, and the new TH applies from the next reload.

## Timing
- Reset, synchronous and active-high, sets:
  - TH = 0, TL = 0, TCON = 0.
  - LED = 0, DIGI = 0.
  - Switch synchronizer = 0, SYSTICK = 0.
  - Therefore `irqout` = 0, `led` = 8'h00, `digi` = 12'h000.
  - `rdata` is 0 unless a read is in progress.
- Reset asserted mid-count overrides any write or tick in the same cycle.
- Write latency: the register and its output pin update at the edge that samples `wr`, and are visible in the next cycle.
- Read latency: 0 cycles, combinational from `addr`/`rd`, so the monocyclic CPU completes the load in one cycle.
- Overflow to `irqout`: `irqout` rises in the cycle after the edge where TL = FFFFFFFF is reloaded.
- `switch` to SWITCH readback: `SW_SYNC_STAGES` edges.

## Configuration
- `PERIPH_SYSTICK_EN` defined:
  - Offset 0x18 is a read-only 32-bit free-running cycle counter, incremented every cycle after reset and wrapping at 2^32.
  - Writes to 0x18 are ignored.
- Not defined:
  - No counter is instantiated.
  - Offset 0x18 reads 0 like any unmapped offset.

## Test plan
- Reset then read all offsets: every read returns 0, and `irqout` = 0, `led` = 0, `digi` = 0.
- Timer overflow:
  - Stimulus: write TH = 32'hFFFFFFF0, then TL = 32'hFFFFFFFE, then TCON = 3.
  - Expected: TL = FFFFFFFF after 1 cycle, then TL = FFFFFFF0 and TCON = 7 after 2 cycles, `irqout` = 1; the next reload follows 16 cycles later.
  - Then write TCON = 3: `irqout` = 0 the next cycle and counting continues.
- Collisions:
  - Write TL = 5 in the overflow cycle: TL = 5, not TH.
  - Write TCON = 3 in the overflow cycle: TCON = 3 and `irqout` stays 0.
- Register width masking:
  - Write LED = 32'hDEADBEA5: `led` = 8'hA5 and the readback is 32'h000000A5.
  - Write DIGI = 32'hFFFFF3C6: `digi` = 12'h3C6.
- Decode boundaries:
  - Drive `switch` = 8'h5A: SWITCH reads 32'h0000005A only after 2 edges.
  - Read address 0x40000030 and address 0x00000010 with `rd` = 1: both return 0.
  - Write to 0x40000010: no state change.
- With `PERIPH_SYSTICK_EN`: two reads of 0x18 taken 10 cycles apart differ by exactly 10. Without it, 0x18 reads 0.
